br_flow_fork_select_multihot_fifo: RTL
======================================

# br_flow_fork_select_multihot_fifo

Buffered multicast fork. Each accepted push carries a payload and a multihot destination mask into a Depth-entry FIFO. The head entry is offered to every selected pop flow, and each flow accepts it independently. The entry retires once all of its selected flows have taken it. It sits between one producer and NumFlows consumers, and replaces the combinational select-fork wherever pop_valid must be stable and consumers must not stall each other combinationally.

## Interface
- NumFlows, 2: number of pop flows; must be ≥ 2.
- Width, 1: payload width; must be ≥ 1.
- Depth, 2: FIFO entries; must be ≥ 1; non-power-of-two supported.
- EnableAssertFinalNotValid, 1: assert no pop_valid and push_valid at end of test.

- clk  input  1  clock; one clock domain, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- push_ready  output  1  FIFO can accept an entry.
- push_valid  input  1  push request.
- push_data  input  Width  payload.
- push_select_multihot  input  NumFlows  destination flows; nonzero whenever push_valid.
- pop_ready  input  NumFlows  per-flow ready.
- pop_valid  output  NumFlows  per-flow valid; stable until accepted.
- pop_data  output  Width  head payload, shared by all flows.
- items  output  $clog2(Depth+1)  current occupancy.

## Operation
- Each storage entry holds {data[Width], remaining[NumFlows]}. State is wr_ptr, rd_ptr (both 0..Depth-1) and count (0..Depth).
- push_ready = !rst && (count < Depth). It has no combinational dependency on pop_ready.
- Push handshake is push_valid && push_ready. It writes data and remaining = push_select_multihot at wr_ptr, then wr_ptr advances.
- pop_valid[i] = (count != 0) && remaining[rd_ptr][i]. pop_data = data[rd_ptr].
- Pop handshake on flow i is pop_valid[i] && pop_ready[i]. It clears remaining[rd_ptr][i].
- Retire: when the head's remaining mask, after this cycle's clears, is all zero, rd_ptr advances and count decrements in the same edge.
  - Several flows may accept in the same cycle.
  - The last accepting flow retires the entry.
- Pointer wrap: a pointer at Depth-1 increments to 0.
- Simultaneous push and retire: count is unchanged and both pointers advance.
- Full with a retire in the same cycle: push_ready stays 0 (no full-throughput pass-through), so items stays Depth and then drops to Depth-1 next cycle.
- Empty: all pop_valid are 0 and pop_data is don't-care.
- Flows not selected by the head entry see pop_valid = 0, and their pop_ready is ignored.
- Integration assertions (when assertions are enabled):
  - push_valid implies nonzero select.
  - push_valid and select are known.
  - push_valid, data and select are stable while backpressured.
  - Static checks on parameters.
- Implementation assertions:
  - pop_valid[i] stable until accepted.
  - count ≤ Depth.
  - items == count.

## Timing
- Reset values (asynchronous, applied immediately on rst rise):
  - count = 0, wr_ptr = 0, rd_ptr = 0, all remaining = 0.
  - pop_valid = 0, items = 0, push_ready = 0 while rst is high.
- The data array needs no reset.
- After rst falls, push_ready = 1 in the first cycle.
- Base latency: push accepted at edge N gives pop_valid visible in cycle N+1.
- Throughput: one push and one retire per cycle when Depth ≥ 2. Depth = 1 sustains one entry every two cycles.
- Reset mid-operation discards all entries. Partially delivered entries are not resumed.

## Configuration
- Macro BR_FLOW_FORK_SELECT_MULTIHOT_FIFO_BYPASS_EN.
- Undefined: behaviour exactly as above, with 1-cycle latency.
- Defined, when count == 0:
  - pop_valid[i] = push_valid && push_select_multihot[i], and pop_data = push_data.
  - Flows with pop_ready take the payload in the same cycle (0-cycle latency).
  - If every selected flow accepts, nothing is written and count stays 0.
  - Otherwise the entry is written with remaining = select & ~pop_ready, and count becomes 1.
  - push_ready is unchanged (1 when empty).
- Defined, when count != 0: identical to the undefined case. A push never bypasses older entries.

## Test plan
- Reset, then push data=0xA5 with select=0b11 and both pop_ready=1 → pop_valid=0b11 one cycle later with pop_data=0xA5; entry retires; items returns 0.
- Push select=0b11 with pop_ready=0b01 held → flow 0 accepts; pop_valid=0b10 stays high with data stable; raising pop_ready[1] two cycles later retires the entry.
- Depth=2, pop_ready=0: three pushes → items=2 and push_ready=0; a single full retire while push_valid is high leaves items=2 that cycle and push_ready=1 the next.
- Depth=3: ten pushes with rotating selects 0b01, 0b10, 0b11 and random pop_ready → every flow sees exactly its selected payloads in order across pointer wrap; final items=0.
- Assert rst with two entries queued and one partially delivered → pop_valid=0 and items=0 immediately; after release push_ready=1 and no stale data appears.
- BYPASS_EN defined, empty FIFO, push 0x3C with select=0b11 and pop_ready=0b10 → flow 1 takes 0x3C in the same cycle; items=1 and pop_valid=0b01 in the next cycle.

Source files
------------

// File: rtl/br_flow_fork_select_multihot_fifo.sv
// br_flow_fork_select_multihot_fifo: buffered multicast fork.
// Each push carries a payload and a multihot destination mask into a Depth-entry FIFO.
// The head entry is offered to every selected pop flow. Each flow accepts it on its own.
// The entry retires once every selected flow has taken it.
// Optional feature: define BR_FLOW_FORK_SELECT_MULTIHOT_FIFO_BYPASS_EN to add a
// 0-cycle bypass path that is used while the FIFO is empty.
module br_flow_fork_select_multihot_fifo #(
  parameter int unsigned NumFlows = 2,
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2,
  parameter bit EnableAssertFinalNotValid = 1'b1,
  localparam int unsigned CountW = $clog2(Depth + 1)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                push_ready,
  input  logic                push_valid,
  input  logic [Width-1:0]    push_data,
  input  logic [NumFlows-1:0] push_select_multihot,
  input  logic [NumFlows-1:0] pop_ready,
  output logic [NumFlows-1:0] pop_valid,
  output logic [Width-1:0]    pop_data,
  output logic [CountW-1:0]   items
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CountW-1:0] DepthCount = CountW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0]    data_q      [Depth];
  logic [NumFlows-1:0] remaining_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]   count_q, count_d;

  logic                empty;
  logic                push_fire;
  logic                write_en;
  logic                retire;
  logic [NumFlows-1:0] head_rem;
  logic [NumFlows-1:0] head_rem_next;
  logic [NumFlows-1:0] pop_fire;
  logic [NumFlows-1:0] write_rem;

  // Handshakes, head presentation, retire decision and next-state for pointers/count.
  always_comb begin
    empty      = (count_q == '0);
    // No full-throughput pass-through: a retire while full does not open push_ready.
    push_ready = !rst && (count_q < DepthCount);
    push_fire  = push_valid && push_ready;
    head_rem   = remaining_q[rd_ptr_q];
    pop_valid  = empty ? '0 : head_rem;
    pop_data   = data_q[rd_ptr_q];
    write_rem  = push_select_multihot;
    write_en   = push_fire;
`ifdef BR_FLOW_FORK_SELECT_MULTIHOT_FIFO_BYPASS_EN
    if (empty) begin
      // Present the incoming push directly; only flows that do not take it now stay pending.
      pop_valid = (push_valid && !rst) ? push_select_multihot : '0;
      pop_data  = push_data;
      write_rem = push_select_multihot & ~pop_ready;
      if (write_rem == '0) begin
        write_en = 1'b0;
      end
    end
`endif
    pop_fire      = pop_valid & pop_ready;
    head_rem_next = head_rem & ~pop_fire;
    retire        = !empty && (head_rem_next == '0);

    wr_ptr_d = wr_ptr_q;
    if (write_en) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (retire) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    if (write_en && !retire) begin
      count_d = count_q + 1'b1;
    end else if (!write_en && retire) begin
      count_d = count_q - 1'b1;
    end

    items = count_q;
  end

  // Control state: pointers, occupancy and per-entry pending-flow masks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Head clear and tail write never alias: a write while non-empty implies not full.
      if (!empty) begin
        remaining_q[rd_ptr_q] <= head_rem_next;
      end
      if (write_en) begin
        remaining_q[wr_ptr_q] <= write_rem;
      end
    end
  end

  // Payload storage; unreset because the remaining masks gate visibility.
  always_ff @(posedge clk) begin
    if (write_en) begin
      data_q[wr_ptr_q] <= push_data;
    end
  end

`ifndef SYNTHESIS
  a_params: assert property (@(posedge clk) (NumFlows >= 2) && (Width >= 1) && (Depth >= 1));

  a_push_select_nonzero: assert property (@(posedge clk) disable iff (rst)
    push_valid |-> (push_select_multihot != '0));

  a_push_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(push_valid) && (!push_valid || !$isunknown(push_select_multihot)));

  a_push_stable: assert property (@(posedge clk) disable iff (rst)
    (push_valid && !push_ready) |=>
      (push_valid && $stable(push_data) && $stable(push_select_multihot)));

  for (genvar i = 0; i < NumFlows; i++) begin : g_pop_stable
    a_pop_valid_stable: assert property (@(posedge clk) disable iff (rst)
      (pop_valid[i] && !pop_ready[i]) |=> (pop_valid[i] && $stable(pop_data)));
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= DepthCount);

  a_items_count: assert property (@(posedge clk) disable iff (rst) items == count_q);

  final begin
    if (EnableAssertFinalNotValid) begin
      a_final_idle: assert (!push_valid && (pop_valid == '0));
    end
  end
`endif

endmodule
